// File: rtl/candidate_stream_sender_pkg.sv
// rtl/candidate_stream_sender_pkg.sv - widths and candidate record shared with the duplication filter
package candidate_stream_sender_pkg;

    localparam int LLR_Width  = 5;
    localparam int Q_Width    = 6;
    localparam int MAX_LLR    = 31;
    localparam int Filter_Cap = 32;

    typedef struct packed {
        logic [LLR_Width:0] llr;
        logic [Q_Width:0]   q;
    } cand_t;

endpackage

// File: rtl/cand_pingpong_buf.sv
// rtl/cand_pingpong_buf.sv - two candidate banks with commit flags; one write port, one read port
module cand_pingpong_buf
    import candidate_stream_sender_pkg::cand_t;
#(
    parameter int List_Len = 32,
    localparam int AW = $clog2(List_Len)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  cand_t         wr_data_i,
    input  logic          wr_commit_i,
    output logic          wr_ready_o,
    output logic          send_pending_o,
    input  logic          swap_i,
    input  logic          release_i,
    input  logic [AW-1:0] rd_addr_i,
    output cand_t         rd_data_o
);

    cand_t      bank0_q [List_Len];
    cand_t      bank1_q [List_Len];
    logic       fill_sel_q, fill_sel_d;
    logic [1:0] committed_q, committed_d;
    logic       wr_ready_q, wr_ready_d;

    // The send bank is always the one the fill side is not pointing at.
    always_comb begin
        committed_d = committed_q;
        fill_sel_d  = fill_sel_q;
        if (wr_commit_i && wr_ready_q) begin
            committed_d[fill_sel_q] = 1'b1;
        end
        if (release_i) begin
            committed_d[~fill_sel_q] = 1'b0;
        end
        if (swap_i) begin
            fill_sel_d = ~fill_sel_q;
        end
        wr_ready_d = ~committed_d[fill_sel_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            committed_q <= 2'b00;
            fill_sel_q  <= 1'b0;
            wr_ready_q  <= 1'b1;
        end else begin
            committed_q <= committed_d;
            fill_sel_q  <= fill_sel_d;
            wr_ready_q  <= wr_ready_d;
        end
    end

    // Contents survive reset; only the flags above are cleared.
    always_ff @(posedge clk) begin
        if (wr_en_i && wr_ready_q) begin
            if (fill_sel_q) begin
                bank1_q[wr_addr_i] <= wr_data_i;
            end else begin
                bank0_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    assign rd_data_o      = fill_sel_q ? bank0_q[rd_addr_i] : bank1_q[rd_addr_i];
    assign wr_ready_o     = wr_ready_q;
    assign send_pending_o = committed_q[fill_sel_q];

endmodule

// File: rtl/candidate_stream_sender.sv
// rtl/candidate_stream_sender.sv - streams committed candidate lists into the duplication filter
module candidate_stream_sender
    import candidate_stream_sender_pkg::cand_t;
#(
    parameter int LLR_Width  = candidate_stream_sender_pkg::LLR_Width,
    parameter int Q_Width    = candidate_stream_sender_pkg::Q_Width,
    parameter int List_Len   = 32,
    parameter int Filter_Cap = candidate_stream_sender_pkg::Filter_Cap
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [$clog2(List_Len)-1:0] wr_addr,
    input  logic [LLR_Width:0]          wr_llr,
    input  logic [Q_Width:0]            wr_q,
    input  logic                        wr_commit,
    output logic                        wr_ready,
    output logic                        Output_Valid,
    output logic [LLR_Width:0]          Output_LLR,
    output logic [Q_Width:0]            Output_Q,
    input  logic                        full,
    output logic                        msg_done,
    output logic                        order_err
);

    localparam int AW = $clog2(List_Len);
    localparam int IW = AW + 1;
    localparam int CW = $clog2(Filter_Cap + 2);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRIME  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    localparam logic [IW-1:0] LAST_IDX  = IW'(List_Len);
    localparam logic [CW-1:0] CNT_FULL  = CW'(2);
    localparam logic [CW-1:0] CNT_DRAIN = CW'(Filter_Cap + 1);

    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_dec;
    logic               valid_q, valid_d;
    logic [LLR_Width:0] llr_q, llr_d;
    logic [Q_Width:0]   q_q, q_d;
    logic [LLR_Width:0] prev_llr_q, prev_llr_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic  swap, rel, send_pending;
    cand_t wr_data, rd_data;

    always_comb begin
        wr_data.llr = wr_llr;
        wr_data.q   = wr_q;
    end

    cand_pingpong_buf #(
        .List_Len(List_Len)
    ) u_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .wr_commit_i   (wr_commit),
        .wr_ready_o    (wr_ready),
        .send_pending_o(send_pending),
        .swap_i        (swap),
        .release_i     (rel),
        .rd_addr_i     (idx_q[AW-1:0]),
        .rd_data_o     (rd_data)
    );

    // The FSM runs one cycle ahead of the output registers: STREAM with index i
    // is presenting beat i while loading entry i; index List_Len presents the last entry.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        llr_d      = llr_q;
        q_d        = q_q;
        prev_llr_d = prev_llr_q;
        err_d      = err_q;
        done_d     = 1'b0;
        swap       = 1'b0;
        rel        = 1'b0;
        cnt_dec    = cnt_q - CW'(1);
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (send_pending) begin
                    swap    = 1'b1;
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                valid_d = 1'b1;
                llr_d   = rd_data.llr;
                q_d     = rd_data.q;
                idx_d   = '0;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (full) begin
                    valid_d = 1'b0;
                    cnt_d   = CNT_FULL;
                    state_d = ST_FLUSH;
                end else if (idx_q == LAST_IDX) begin
                    valid_d = 1'b0;
                    cnt_d   = CNT_DRAIN;
                    state_d = ST_FLUSH;
                end else begin
                    valid_d    = 1'b1;
                    llr_d      = rd_data.llr;
                    q_d        = rd_data.q;
                    prev_llr_d = rd_data.llr;
                    idx_d      = idx_q + IW'(1);
                    if ((idx_q != '0) && (rd_data.llr < prev_llr_q)) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                cnt_d   = cnt_dec;
                if (cnt_dec == '0) begin
                    done_d  = 1'b1;
                    rel     = 1'b1;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            llr_q      <= '0;
            q_q        <= '0;
            prev_llr_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            llr_q      <= llr_d;
            q_q        <= q_d;
            prev_llr_q <= prev_llr_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign Output_Valid = valid_q;
    assign Output_LLR   = llr_q;
    assign Output_Q     = q_q;
    assign msg_done     = done_q;
    assign order_err    = err_q;

endmodule

// File: tb/tb_candidate_stream_sender.sv
// tb/tb_candidate_stream_sender.sv - self-checking bench for candidate_stream_sender
module tb_candidate_stream_sender;

    localparam int LW  = 5;
    localparam int QW  = 6;
    localparam int LEN = 32;
    localparam int CAP = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [LW:0]   wr_llr;
    logic [QW:0]   wr_q;
    logic          wr_commit;
    logic          wr_ready;
    logic          Output_Valid;
    logic [LW:0]   Output_LLR;
    logic [QW:0]   Output_Q;
    logic          full;
    logic          msg_done;
    logic          order_err;

    always #5 clk = ~clk;

    candidate_stream_sender dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_llr      (wr_llr),
        .wr_q        (wr_q),
        .wr_commit   (wr_commit),
        .wr_ready    (wr_ready),
        .Output_Valid(Output_Valid),
        .Output_LLR  (Output_LLR),
        .Output_Q    (Output_Q),
        .full        (full),
        .msg_done    (msg_done),
        .order_err   (order_err)
    );

    int          tests = 0;
    int          fails = 0;
    logic [LW:0] m_llr [2][LEN];
    logic [QW:0] m_q   [2][LEN];
    bit          err_model = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit descent(input int s, input int upto);
        bit d = 1'b0;
        int top = (upto > LEN - 1) ? LEN - 1 : upto;
        for (int i = 1; i <= top; i++) begin
            if (m_llr[s][i] < m_llr[s][i-1]) d = 1'b1;
        end
        return d;
    endfunction

    task automatic fill_sorted(input int s);
        int v = 0;
        for (int i = 0; i < LEN; i++) begin
            v += $urandom_range(0, 2);
            if (v > 63) v = 63;
            m_llr[s][i] = v[LW:0];
            m_q[s][i]   = 7'($urandom_range(0, 127));
        end
    endtask

    task automatic write_list(input int s);
        for (int i = 0; i < LEN; i++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(i);
            wr_llr  = m_llr[s][i];
            wr_q    = m_q[s][i];
            @(negedge clk);
        end
        wr_en     = 1'b0;
        wr_commit = 1'b1;
        @(negedge clk);
        wr_commit = 1'b0;
    endtask

    // Expected stream: entry 0 twice, then entries 1.., cut after the beat where full is raised.
    task automatic run_msg(input string tag, input int s, input int full_beat, input int exp_lat);
        int lat  = 0;
        int nb   = 0;
        int nlow = 0;
        int idx;
        while (Output_Valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, lat, exp_lat);
        while (Output_Valid === 1'b1 && nb < LEN + 2) begin
            idx = (nb == 0) ? 0 : nb - 1;
            if (idx > LEN - 1) idx = LEN - 1;
            check({tag, "/llr"}, Output_LLR, m_llr[s][idx]);
            check({tag, "/q"}, Output_Q, m_q[s][idx]);
            check({tag, "/order_err"}, order_err, err_model | descent(s, nb - 1));
            if (nb == full_beat) full = 1'b1;
            nb++;
            @(negedge clk);
            full = 1'b0;
        end
        check({tag, "/beats"}, nb, (full_beat >= 0) ? full_beat + 1 : LEN + 1);
        while (msg_done !== 1'b1 && nlow < 200) begin
            check({tag, "/valid_low"}, Output_Valid, 0);
            nlow++;
            @(negedge clk);
        end
        check({tag, "/flush_cycles"}, nlow, (full_beat >= 0) ? 2 : CAP + 1);
        err_model = err_model | descent(s, nb - 2);
        check({tag, "/done_valid"}, Output_Valid, 0);
        @(negedge clk);
        check({tag, "/done_pulse"}, msg_done, 0);
    endtask

    initial begin
        int nd, nv, fb;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_llr = '0; wr_q = '0;
        wr_commit = 1'b0; full = 1'b0;
        repeat (3) @(negedge clk);
        check("reset/valid", Output_Valid, 0);
        check("reset/llr", Output_LLR, 0);
        check("reset/q", Output_Q, 0);
        check("reset/msg_done", msg_done, 0);
        check("reset/order_err", order_err, 0);
        check("reset/wr_ready", wr_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < LEN; i++) begin
            m_llr[0][i] = 6'(i);
            m_q[0][i]   = 7'(i);
        end
        write_list(0);
        run_msg("ramp", 0, -1, 2);

        fill_sorted(0);
        write_list(0);
        run_msg("full10", 0, 10, 2);
        check("idle/wr_ready", wr_ready, 1);

        fill_sorted(1);
        write_list(1);
        run_msg("full_last", 1, LEN, 2);

        fill_sorted(0);
        fill_sorted(1);
        m_llr[1][0] = 6'd1;
        m_q[1][0]   = 7'd5;
        write_list(0);
        fork
            run_msg("b2b_first", 0, -1, 2);
            begin
                repeat (3) @(negedge clk);
                write_list(1);
                check("b2b/wr_ready_both", wr_ready, 0);
                wr_en = 1'b1; wr_addr = '0; wr_llr = 6'h2A; wr_q = 7'h2A; wr_commit = 1'b1;
                @(negedge clk);
                wr_en = 1'b0; wr_commit = 1'b0;
            end
        join
        check("b2b/wr_ready_after_swap", wr_ready, 1);
        run_msg("b2b_second", 1, -1, 1);

        for (int i = 0; i < LEN; i++) begin
            m_llr[0][i] = 6'(4 + i);
            m_q[0][i]   = 7'($urandom_range(0, 127));
        end
        m_llr[0][0] = 6'd3;
        m_llr[0][1] = 6'd5;
        m_llr[0][2] = 6'd4;
        write_list(0);
        run_msg("order", 0, -1, 2);
        check("order/sticky", order_err, 1);

        fill_sorted(1);
        write_list(1);
        repeat (2) @(negedge clk);
        check("rst/first_beat", Output_Valid, 1);
        repeat (7) @(negedge clk);
        check("rst/beat7", Output_Valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst/valid_async", Output_Valid, 0);
        err_model = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst/wr_ready", wr_ready, 1);
        check("rst/order_err", order_err, 0);
        nd = 0;
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (msg_done === 1'b1) nd++;
            if (Output_Valid === 1'b1) nv++;
        end
        check("rst/no_done", nd, 0);
        check("rst/no_valid", nv, 0);

        for (int i = 0; i < LEN; i++) begin
            m_llr[0][i] = 6'($urandom_range(0, 63));
            m_q[0][i]   = 7'($urandom_range(0, 127));
        end
        fb = $urandom_range(1, LEN);
        write_list(0);
        run_msg("random", 0, fb, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
